// File: rtl/reg_bank_ctl.sv
// Bank of NUM_REGS registers with load/inc/dec ops, result flags and a
// multi-cycle clear-all sweep. Two independent combinational read ports.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  ST_IDLE  | ops accepted; clr_all starts a sweep
//  ST_SWEEP | one register cleared per cycle, ops and clr_all ignored
module reg_bank_ctl #(
    parameter int               WIDTH     = 8,
    parameter int               NUM_REGS  = 4,
    parameter int               ADDR_W    = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               SATURATE  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [1:0]        op_code,
    input  logic [ADDR_W-1:0] op_addr,
    input  logic [WIDTH-1:0]  op_data,
    input  logic              clr_all,
    output logic              busy,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [WIDTH-1:0]  rd_data_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [WIDTH-1:0]  rd_data_b,
    output logic              carry,
    output logic              zero
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_t;

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_INC  = 2'b10;
    localparam logic [1:0] OP_DEC  = 2'b11;

    localparam logic [WIDTH-1:0]  ZERO_W   = '0;
    localparam logic [WIDTH-1:0]  ONES_W   = '1;
    localparam logic [WIDTH-1:0]  ONE_W    = WIDTH'(1);
    localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);
    localparam logic [ADDR_W:0]   NREGS_X  = (ADDR_W + 1)'(NUM_REGS);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              carry_q, carry_d;
    logic              zero_q, zero_d;
    logic [WIDTH-1:0]  regs_q [NUM_REGS];
    logic [WIDTH-1:0]  regs_d [NUM_REGS];

    logic              accept;
    logic [WIDTH-1:0]  cur_val;
    logic [WIDTH-1:0]  res_val;
    logic              res_carry;

    assign busy     = (state_q == ST_SWEEP);
    assign op_ready = ~busy;
    assign carry    = carry_q;
    assign zero     = zero_q;

    assign accept = op_valid & op_ready & (op_code != OP_NOP) &
                    ({1'b0, op_addr} < NREGS_X);

    // Operand fetch; out-of-range addresses never reach the write below.
    always_comb begin
        cur_val = ZERO_W;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (op_addr == ADDR_W'(i)) begin
                cur_val = regs_q[i];
            end
        end
    end

    always_comb begin
        res_val   = cur_val;
        res_carry = 1'b0;
        case (op_code)
            OP_LOAD: begin
                res_val = op_data;
            end
            OP_INC: begin
                if (cur_val == ONES_W) begin
                    res_carry = 1'b1;
                    res_val   = (SATURATE != 0) ? ONES_W : ZERO_W;
                end else begin
                    res_val = cur_val + ONE_W;
                end
            end
            OP_DEC: begin
                if (cur_val == ZERO_W) begin
                    res_carry = 1'b1;
                    res_val   = (SATURATE != 0) ? ZERO_W : ONES_W;
                end else begin
                    res_val = cur_val - ONE_W;
                end
            end
            default: begin
                res_val   = cur_val;
                res_carry = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        zero_d  = zero_q;
        regs_d  = regs_q;

        if (accept) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (op_addr == ADDR_W'(i)) begin
                    regs_d[i] = res_val;
                end
            end
            carry_d = res_carry;
            zero_d  = (res_val == ZERO_W);
        end

        case (state_q)
            ST_IDLE: begin
                if (clr_all) begin
                    state_d = ST_SWEEP;
                    idx_d   = '0;
                end
            end
            ST_SWEEP: begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (idx_q == ADDR_W'(i)) begin
                        regs_d[i] = ZERO_W;
                    end
                end
                if (idx_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + ONE_A;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= RESET_VAL;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
            regs_q  <= regs_d;
        end
    end

    // Read ports: unmapped addresses read as zero.
    always_comb begin
        rd_data_a = ZERO_W;
        rd_data_b = ZERO_W;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_addr_a == ADDR_W'(i)) begin
                rd_data_a = regs_q[i];
            end
            if (rd_addr_b == ADDR_W'(i)) begin
                rd_data_b = regs_q[i];
            end
        end
    end

endmodule

// File: tb/tb_reg_bank_ctl.sv
// Bench for reg_bank_ctl: wrapping, saturating and 3-register instances
// share one stimulus stream; vector table checked through a scoreboard queue.
module tb_reg_bank_ctl;

    logic       clk;
    logic       rst_n;
    logic       op_valid;
    logic [1:0] op_code;
    logic [1:0] op_addr;
    logic [7:0] op_data;
    logic       clr_all;
    logic [1:0] rd_addr_a;
    logic [1:0] rd_addr_b;

    logic [7:0] rda0, rdb0, rda1, rdb1, rda2, rdb2;
    logic       busy0, busy1, busy2;
    logic       rdy0, rdy1, rdy2;
    logic       c0, c1, c2;
    logic       z0, z1, z2;

    int n_cmp = 0;
    int n_err = 0;

    reg_bank_ctl #(.WIDTH(8), .NUM_REGS(4), .ADDR_W(2), .RESET_VAL(8'h5A), .SATURATE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(rdy0), .op_code(op_code),
        .op_addr(op_addr), .op_data(op_data), .clr_all(clr_all), .busy(busy0),
        .rd_addr_a(rd_addr_a), .rd_data_a(rda0), .rd_addr_b(rd_addr_b), .rd_data_b(rdb0),
        .carry(c0), .zero(z0));

    reg_bank_ctl #(.WIDTH(8), .NUM_REGS(4), .ADDR_W(2), .RESET_VAL(8'h5A), .SATURATE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(rdy1), .op_code(op_code),
        .op_addr(op_addr), .op_data(op_data), .clr_all(clr_all), .busy(busy1),
        .rd_addr_a(rd_addr_a), .rd_data_a(rda1), .rd_addr_b(rd_addr_b), .rd_data_b(rdb1),
        .carry(c1), .zero(z1));

    reg_bank_ctl #(.WIDTH(8), .NUM_REGS(3), .ADDR_W(2), .RESET_VAL(8'h5A), .SATURATE(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(rdy2), .op_code(op_code),
        .op_addr(op_addr), .op_data(op_data), .clr_all(clr_all), .busy(busy2),
        .rd_addr_a(rd_addr_a), .rd_data_a(rda2), .rd_addr_b(rd_addr_b), .rd_data_b(rdb2),
        .carry(c2), .zero(z2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       valid;
        logic [1:0] code;
        logic [1:0] addr;
        logic [7:0] data;
        logic [7:0] exp_data;
        logic       exp_c;
        logic       exp_z;
    } vec_t;

    typedef struct {
        int         idx;
        logic [1:0] addr;
        logic [7:0] data;
        logic       c;
        logic       z;
    } exp_t;

    vec_t vecs [12];
    exp_t sb_q [$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_op(input logic v, input logic [1:0] code, input logic [1:0] addr,
                            input logic [7:0] data);
        op_valid = v;
        op_code  = code;
        op_addr  = addr;
        op_data  = data;
    endtask

    task automatic run_op(input logic [1:0] code, input logic [1:0] addr, input logic [7:0] data);
        drive_op(1'b1, code, addr, data);
        tick();
        op_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] sweep_vals [4];
        exp_t e;

        // op, addr, data, expected r[addr], carry, zero  (dut0, wrapping)
        vecs[0]  = '{1'b1, 2'b01, 2'd2, 8'h3C, 8'h3C, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 2'b01, 2'd1, 8'hFF, 8'hFF, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 2'b10, 2'd1, 8'h00, 8'h00, 1'b1, 1'b1};
        vecs[3]  = '{1'b1, 2'b11, 2'd1, 8'h00, 8'hFF, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 2'b01, 2'd0, 8'h05, 8'h05, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 2'b10, 2'd0, 8'h00, 8'h06, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 2'b11, 2'd3, 8'h00, 8'h59, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 2'b01, 2'd3, 8'h00, 8'h00, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 2'b00, 2'd2, 8'h77, 8'h3C, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 2'b01, 2'd0, 8'h99, 8'h06, 1'b0, 1'b1};
        vecs[10] = '{1'b1, 2'b11, 2'd0, 8'h00, 8'h05, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 2'b10, 2'd2, 8'h00, 8'h3D, 1'b0, 1'b0};

        rst_n = 1'b0;
        clr_all = 1'b0;
        drive_op(1'b0, 2'b00, 2'd0, 8'h00);
        rd_addr_a = 2'd0;
        rd_addr_b = 2'd0;
        tick();
        tick();
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            rd_addr_a = 2'(i);
            rd_addr_b = 2'(i);
            #1;
            chk($sformatf("reset_rd_a%0d", i), rda0, 8'h5A);
            chk($sformatf("reset_rd_b%0d", i), rdb0, 8'h5A);
        end
        chk("reset_busy", busy0, 1'b0);
        chk("reset_carry", c0, 1'b0);
        chk("reset_zero", z0, 1'b0);
        chk("reset_ready", rdy0, 1'b1);
        rd_addr_a = 2'd3;
        #1;
        chk("n3_rd_unmapped_after_reset", rda2, 8'h00);

        rd_addr_a = 2'd2;
        rd_addr_b = 2'd2;
        drive_op(1'b1, 2'b01, 2'd2, 8'h3C);
        #1;
        chk("same_cycle_old_value", rda0, 8'h5A);
        tick();
        op_valid = 1'b0;
        #1;
        chk("load_rd_a", rda0, 8'h3C);
        chk("load_rd_b", rdb0, 8'h3C);
        chk("load_zero", z0, 1'b0);

        for (int i = 0; i < 12; i++) begin
            drive_op(vecs[i].valid, vecs[i].code, vecs[i].addr, vecs[i].data);
            sb_q.push_back('{i, vecs[i].addr, vecs[i].exp_data, vecs[i].exp_c, vecs[i].exp_z});
            tick();
            op_valid = 1'b0;
            if (sb_q.size() == 0) begin
                chk("scoreboard_empty", 32'd0, 32'd1);
            end else begin
                e = sb_q.pop_front();
                rd_addr_a = e.addr;
                rd_addr_b = e.addr;
                #1;
                chk($sformatf("vec%0d_rd_a", e.idx), rda0, e.data);
                chk($sformatf("vec%0d_rd_b", e.idx), rdb0, e.data);
                chk($sformatf("vec%0d_carry", e.idx), c0, e.c);
                chk($sformatf("vec%0d_zero", e.idx), z0, e.z);
            end
        end

        rd_addr_a = 2'd3;
        run_op(2'b01, 2'd3, 8'hFF);
        run_op(2'b10, 2'd3, 8'h00);
        #1;
        chk("sat_inc_val", rda1, 8'hFF);
        chk("sat_inc_carry", c1, 1'b1);
        chk("sat_inc_zero", z1, 1'b0);
        run_op(2'b01, 2'd3, 8'h00);
        run_op(2'b11, 2'd3, 8'h00);
        #1;
        chk("sat_dec_val", rda1, 8'h00);
        chk("sat_dec_carry", c1, 1'b1);
        chk("sat_dec_zero", z1, 1'b1);

        run_op(2'b01, 2'd2, 8'h07);
        run_op(2'b01, 2'd3, 8'h00);
        rd_addr_a = 2'd3;
        rd_addr_b = 2'd2;
        #1;
        chk("n3_oob_rd", rda2, 8'h00);
        chk("n3_oob_r2_kept", rdb2, 8'h07);
        chk("n3_oob_carry_hold", c2, 1'b0);
        chk("n3_oob_zero_hold", z2, 1'b0);

        sweep_vals[0] = 8'h11;
        sweep_vals[1] = 8'h22;
        sweep_vals[2] = 8'h33;
        sweep_vals[3] = 8'h44;
        for (int i = 0; i < 4; i++) begin
            run_op(2'b01, 2'(i), sweep_vals[i]);
        end
        drive_op(1'b1, 2'b01, 2'd2, 8'h77);
        clr_all = 1'b1;
        tick();
        clr_all = 1'b0;
        op_valid = 1'b0;
        rd_addr_a = 2'd2;
        rd_addr_b = 2'd0;
        #1;
        chk("sweep_start_busy", busy0, 1'b1);
        chk("sweep_start_ready", rdy0, 1'b0);
        chk("sweep_edge_op_done", rda0, 8'h77);
        chk("sweep_r0_not_yet", rdb0, 8'h11);
        chk("sweep_edge_op_zero", z0, 1'b0);

        drive_op(1'b1, 2'b01, 2'd0, 8'h99);
        clr_all = 1'b1;
        for (int j = 0; j < 4; j++) begin
            tick();
            rd_addr_a = 2'(j);
            rd_addr_b = 2'((j + 1) % 4);
            #1;
            chk($sformatf("sweep_clr_r%0d", j), rda0, 8'h00);
            chk($sformatf("sweep_busy_%0d", j), busy0, (j < 3) ? 1'b1 : 1'b0);
            if (j < 2) begin
                chk($sformatf("sweep_pending_r%0d", j + 1), rdb0,
                    (j == 1) ? 8'h77 : sweep_vals[j + 1]);
            end
        end
        op_valid = 1'b0;
        clr_all = 1'b0;
        rd_addr_a = 2'd0;
        #1;
        chk("sweep_op_ignored", rda0, 8'h00);
        chk("sweep_flags_carry", c0, 1'b0);
        chk("sweep_flags_zero", z0, 1'b0);
        tick();
        chk("sweep_no_restart", busy0, 1'b0);

        clr_all = 1'b1;
        tick();
        clr_all = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midsweep_rst_busy", busy0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            rd_addr_a = 2'(i);
            #1;
            chk($sformatf("midsweep_rst_r%0d", i), rda0, 8'h5A);
        end
        tick();
        chk("midsweep_rst_stays_idle", busy0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
